// File: rtl/hs_sync_serializer_if.sv
// Byte-side handshake and serial-line signals of the HS sync serializer.
// The master side feeds bytes and requests bursts; the slave side is the serializer.
interface hs_sync_serializer_if;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       hs_tx_data;
    logic       hs_tx_en;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_req, tx_data, tx_valid,
        input  tx_ready, hs_tx_data, hs_tx_en, tx_busy, tx_done
    );

    modport slave (
        input  tx_req, tx_data, tx_valid,
        output tx_ready, hs_tx_data, hs_tx_en, tx_busy, tx_done
    );
endinterface

// File: rtl/hs_sync_serializer.sv
// HS-mode transmit serializer: HS-zero preamble, sync word, LSB-first payload
// bytes from the TX FIFO, then an inverted-bit trail; one line bit per clock.
module hs_sync_serializer #(
    parameter int         ZERO_LEN     = 4,
    parameter logic [5:0] SYNC_PATTERN = 6'b101110,
    parameter int         TRAIL_LEN    = 3
) (
    input logic               RxDDRClkHS,
    input logic               RST,
    hs_sync_serializer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ZERO  = 3'd1,
        SYNC  = 3'd2,
        DATA  = 3'd3,
        TRAIL = 3'd4
    } state_t;

    localparam logic [3:0] ZERO_LAST  = 4'(ZERO_LEN);
    localparam logic [3:0] TRAIL_LAST = 4'(TRAIL_LEN);

    state_t     state_r;
    logic [3:0] cnt_r;
    logic [7:1] shift_r;
    logic       line_r;
    logic       en_r;
    logic       done_r;
    logic       ready_s;

    // Byte request strobe: last sync bit or last data bit is on the line.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            SYNC:    ready_s = (cnt_r == 4'd5);
            DATA:    ready_s = (cnt_r == 4'd7);
            default: ready_s = 1'b0;
        endcase
    end

    assign bus.tx_ready   = ready_s;
    assign bus.hs_tx_data = line_r;
    assign bus.hs_tx_en   = en_r;
    assign bus.tx_done    = done_r;
    assign bus.tx_busy    = (state_r != IDLE);

    // Burst sequencer; cnt_r holds the index of the bit currently on the line.
    always_ff @(posedge RxDDRClkHS or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            shift_r <= 7'd0;
            line_r  <= 1'b0;
            en_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    line_r <= 1'b0;
                    if (bus.tx_req) begin
                        state_r <= ZERO;
                        en_r    <= 1'b1;
                        cnt_r   <= 4'd1;
                    end else begin
                        en_r  <= 1'b0;
                        cnt_r <= 4'd0;
                    end
                end
                ZERO: begin
                    if (cnt_r == ZERO_LAST) begin
                        state_r <= SYNC;
                        line_r  <= SYNC_PATTERN[0];
                        cnt_r   <= 4'd0;
                    end else begin
                        line_r <= 1'b0;
                        cnt_r  <= cnt_r + 4'd1;
                    end
                end
                SYNC, DATA: begin
                    if (ready_s) begin
                        if (bus.tx_valid) begin
                            state_r <= DATA;
                            shift_r <= bus.tx_data[7:1];
                            line_r  <= bus.tx_data[0];
                            cnt_r   <= 4'd0;
                        end else begin
                            // Trail is the complement of whatever bit went out last.
                            state_r <= TRAIL;
                            line_r  <= ~line_r;
                            cnt_r   <= 4'd1;
                        end
                    end else if (state_r == SYNC) begin
                        line_r <= SYNC_PATTERN[3'(cnt_r[2:0] + 3'd1)];
                        cnt_r  <= cnt_r + 4'd1;
                    end else begin
                        line_r  <= shift_r[1];
                        shift_r <= {1'b0, shift_r[7:2]};
                        cnt_r   <= cnt_r + 4'd1;
                    end
                end
                TRAIL: begin
                    if (cnt_r == TRAIL_LAST) begin
                        state_r <= IDLE;
                        en_r    <= 1'b0;
                        line_r  <= 1'b0;
                        done_r  <= 1'b1;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    en_r    <= 1'b0;
                    line_r  <= 1'b0;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_sync_serializer.sv
// Directed bench for hs_sync_serializer: captures each burst's line bits and
// handshake activity and compares them with hand-computed bursts.
module tb_hs_sync_serializer;

    logic RxDDRClkHS = 1'b0;
    logic RST        = 1'b0;

    hs_sync_serializer_if bus ();

    hs_sync_serializer dut (
        .RxDDRClkHS (RxDDRClkHS),
        .RST        (RST),
        .bus        (bus)
    );

    always #5 RxDDRClkHS = ~RxDDRClkHS;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] feed_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Runs one burst; outputs are sampled 1 time unit after each rising edge.
    task automatic run_burst(input string name, input bit hold_valid, input int req_pulse_at,
                             input logic [63:0] exp_line, input int exp_len,
                             input int exp_ready, input int exp_consumed);
        logic [63:0] line = 64'd0;
        int en_cycles = 0, ready_cnt = 0, consumed = 0, busy_bad = 0;
        int gap_bad = 0, last_ready = -1, idle_bad = 0;
        bit prev_en = 1'b0, done_ok = 1'b0, finished = 1'b0, consume_next = 1'b0;
        bus.tx_req = 1'b1;
        for (int k = 1; k <= 200 && !finished; k++) begin
            @(posedge RxDDRClkHS);
            #1;
            if (consume_next) begin
                consumed++;
                feed_q.delete(0);
                consume_next = 1'b0;
            end
            if (k == 1) check_eq({name, "_start_en"}, 64'(bus.hs_tx_en), 64'd1);
            bus.tx_req = (k == req_pulse_at);
            if (bus.hs_tx_en) begin
                line = {line[62:0], bus.hs_tx_data};
                en_cycles++;
                if (bus.tx_busy !== 1'b1) busy_bad++;
            end
            if (bus.tx_ready) begin
                ready_cnt++;
                if (last_ready >= 0 && (k - last_ready) != 8) gap_bad++;
                last_ready = k;
            end
            if (bus.tx_done) begin
                if (!bus.hs_tx_en && prev_en && !bus.tx_busy) done_ok = 1'b1;
                finished = 1'b1;
            end
            prev_en = bus.hs_tx_en;
            if (feed_q.size() > 0 && (hold_valid || bus.tx_ready)) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = feed_q[0];
                consume_next = bus.tx_ready;
            end else begin
                bus.tx_valid = 1'b0;
                bus.tx_data  = 8'h00;
            end
        end
        bus.tx_valid = 1'b0;
        bus.tx_req   = 1'b0;
        check_eq({name, "_finished"}, 64'(finished), 64'd1);
        check_eq({name, "_line"}, line, exp_line);
        check_eq({name, "_en_cycles"}, 64'(en_cycles), 64'(exp_len));
        check_eq({name, "_ready_pulses"}, 64'(ready_cnt), 64'(exp_ready));
        check_eq({name, "_consumed"}, 64'(consumed), 64'(exp_consumed));
        check_eq({name, "_ready_gap"}, 64'(gap_bad), 64'd0);
        check_eq({name, "_busy"}, 64'(busy_bad), 64'd0);
        check_eq({name, "_done"}, 64'(done_ok), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge RxDDRClkHS);
            #1;
            if (bus.hs_tx_en || bus.tx_busy || bus.tx_done) idle_bad++;
        end
        check_eq({name, "_idle_after"}, 64'(idle_bad), 64'd0);
    endtask

    initial begin
        bus.tx_req   = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // Held in reset with a pending request: everything stays low.
        for (int k = 0; k < 4; k++) begin
            @(negedge RxDDRClkHS);
            check_eq("reset_outputs",
                     64'({bus.hs_tx_en, bus.hs_tx_data, bus.tx_ready, bus.tx_busy, bus.tx_done}),
                     64'd0);
        end
        @(negedge RxDDRClkHS);
        RST = 1'b1;

        feed_q = {8'hA5};
        run_burst("single_a5", 1'b0, 0, 64'(21'b0000_011101_10100101_000), 21, 2, 1);

        feed_q = {8'h01, 8'hFF, 8'h3C};
        run_burst("b2b", 1'b1, 0,
                  64'(37'b0000_011101_10000000_11111111_00111100_111), 37, 4, 3);

        feed_q = {8'h0F};
        run_burst("underflow", 1'b1, 0, 64'(21'b0000_011101_11110000_111), 21, 2, 1);

        feed_q.delete();
        run_burst("empty", 1'b1, 0, 64'(13'b0000_011101_000), 13, 1, 0);

        feed_q = {8'hA5};
        run_burst("req_busy", 1'b1, 14, 64'(21'b0000_011101_10100101_000), 21, 2, 1);

        // Reset during bit 3 of the second byte (0xFF, so the line is high).
        bus.tx_req   = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        for (int k = 1; k <= 22; k++) begin
            @(posedge RxDDRClkHS);
            #1;
            bus.tx_req = 1'b0;
        end
        check_eq("pre_reset_line", 64'({bus.hs_tx_en, bus.hs_tx_data, bus.tx_busy}), 64'd7);
        #2;
        RST = 1'b0;
        #1;
        check_eq("async_reset",
                 64'({bus.hs_tx_en, bus.hs_tx_data, bus.tx_ready, bus.tx_busy, bus.tx_done}),
                 64'd0);
        repeat (2) @(posedge RxDDRClkHS);
        #1;
        check_eq("reset_hold",
                 64'({bus.hs_tx_en, bus.hs_tx_data, bus.tx_ready, bus.tx_busy, bus.tx_done}),
                 64'd0);
        @(negedge RxDDRClkHS);
        bus.tx_valid = 1'b0;
        RST = 1'b1;

        feed_q = {8'hA5};
        run_burst("recovery", 1'b0, 0, 64'(21'b0000_011101_10100101_000), 21, 2, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
